s1_s2_frame_buffer: RTL

- Producer-side partner of the stage-2 control FSM. It collects the stage-1 output stream into 36-word frames and offers each complete frame over the data_rdy/busy_proc handshake.
- While stage 2 sweeps, it serves random reads addressed by stage 2's dir_counter.
- It is a two-bank ping-pong buffer, so stage 1 can fill one frame while stage 2 consumes the other.

---
 rtl/s1_s2_pkg.sv | 14 +
 rtl/frame_bank_ram.sv | 36 +++
 rtl/s1_s2_frame_buffer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/s1_s2_pkg.sv
// Shared frame geometry and read-side FSM encoding for the stage-1 to stage-2 frame path.
// The frame depth doubles as stage 2's sweep terminal count.
package s1_s2_pkg;

    localparam int FRAME_DEPTH  = 36;
    localparam int FRAME_ADDR_W = 6;

    typedef enum logic [1:0] {
        R_IDLE,
        R_OFFER,
        R_BUSY
    } rd_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: DEPTH x DATA_W RAM, synchronous write, registered read (1 cycle).
// No backpressure; out-of-range read addresses return zero.
module frame_bank_ram
    import s1_s2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = FRAME_DEPTH,
    parameter int ADDR_W = FRAME_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_raddr <= LAST_ADDR) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/s1_s2_frame_buffer.sv
// Ping-pong frame buffer: stage 1 fills one bank while stage 2 sweeps the other; 1-cycle read latency.
// Writes stall (wr_ready low) only when the bank being filled is still full; data_rdy is registered.
module s1_s2_frame_buffer
    import s1_s2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = FRAME_DEPTH,
    parameter int ADDR_W = FRAME_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_data_rdy,
    input  logic              i_busy_proc,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_bank,
    output logic [1:0]        o_fill_level
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [1:0]        r_full;
    logic [1:0]        w_full_nxt;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_rd_bank;
    logic              r_data_rdy;
    logic              r_rd_sel;
    logic              r_rd_clr;

    logic              w_wr_ready;
    logic              w_wr_acc;
    logic              w_wr_last;
    logic              w_release;
    logic [DATA_W-1:0] w_q0;
    logic [DATA_W-1:0] w_q1;

    assign w_wr_ready = !r_full[r_wr_bank];
    assign w_wr_acc   = i_wr_valid && w_wr_ready;
    assign w_wr_last  = w_wr_acc && (r_wr_ptr == LAST_PTR);

    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        w_full_nxt  = r_full;
        case (r_state)
            R_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = R_OFFER;
                end
            end
            R_OFFER: begin
                if (i_busy_proc) begin
                    w_state_nxt = R_BUSY;
                end
            end
            R_BUSY: begin
                if (!i_busy_proc) begin
                    w_state_nxt = R_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: w_state_nxt = R_IDLE;
        endcase
        // Set and clear always target different banks, so both can apply together.
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            r_data_rdy <= 1'b0;
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_bank  <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_clr   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_data_rdy <= (w_state_nxt == R_OFFER);
            r_full     <= w_full_nxt;
            if (w_wr_acc) begin
                if (w_wr_last) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= !r_wr_bank;
                end else begin
                    r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
                end
            end
            if (w_release) begin
                r_rd_bank <= !r_rd_bank;
            end
            r_rd_sel   <= r_rd_bank;
            r_rd_clr   <= 1'b0;
        end
    end

    frame_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_wr_acc && !r_wr_bank),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wr_data),
        .i_raddr (i_rd_addr),
        .o_rdata (w_q0)
    );

    frame_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_wr_acc && r_wr_bank),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wr_data),
        .i_raddr (i_rd_addr),
        .o_rdata (w_q1)
    );

    // RAM output registers are not reset, so the cycle after reset is forced to zero here.
    assign o_rd_data    = r_rd_clr ? '0 : (r_rd_sel ? w_q1 : w_q0);
    assign o_wr_ready   = w_wr_ready;
    assign o_data_rdy   = r_data_rdy;
    assign o_rd_bank    = r_rd_bank;
    assign o_fill_level = {1'b0, r_full[0]} + {1'b0, r_full[1]};

endmodule
